// File: rtl/led_status_port.sv
// led_status_port: memory-mapped self-test status peripheral.
// Turns self-test program stores into the status LEDs {running, succeeded,
// failed, power} and fails a hung program through a heartbeat watchdog.
//
// Ports:
//   ph1        system clock, rising edge
//   reset      asynchronous active-low reset
//   memwrite   store strobe (one cycle per store)
//   dataadr    store byte address
//   writedata  store data; command is writedata[7:0]
//   readdata   {29'b0, timeout, state[1:0]}, decoded from registers
//   outputleds {running, succeeded, failed, power}, registered
//
// Optional build macro: LED_BLINK_EN. When it is defined, the running LED
// blinks with a period of 2^BLINK_BITS cycles. When it is not defined, the
// running LED is steady in RUN and no blink counter is built.
module led_status_port #(
    parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FFF0,
    parameter logic [31:0] HEART_ADDR   = 32'hFFFF_FFF4,
    parameter int unsigned TIMEOUT_BITS = 20,
    parameter int unsigned BLINK_BITS   = 22
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [3:0]  outputleds
);

    localparam int unsigned WD_W = TIMEOUT_BITS;

    localparam logic [7:0] CMD_IDLE = 8'h00;
    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_PASS = 8'h02;
    localparam logic [7:0] CMD_FAIL = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [WD_W-1:0]   wd, wd_nx;
    logic              timeout, timeout_nx;
    logic              run_led_nx;
    logic              status_hit, heart_hit;
    logic [7:0]        cmd;
    logic              unused_data;

    // Bus decode; only the low command byte is meaningful.
    assign status_hit  = memwrite && (dataadr == STATUS_ADDR);
    assign heart_hit   = memwrite && (dataadr == HEART_ADDR);
    assign cmd         = writedata[7:0];
    assign unused_data = ^writedata[31:8];

    // Next-state, watchdog and timeout logic. A store in RUN takes
    // priority over watchdog expiry on the same edge.
    always_comb begin
        state_nx   = state;
        wd_nx      = '0;
        timeout_nx = timeout;
        case (state)
            ST_IDLE: begin
                if (status_hit && cmd == CMD_RUN) begin
                    state_nx   = ST_RUN;
                    timeout_nx = 1'b0;
                end
            end
            ST_RUN: begin
                if (status_hit && cmd == CMD_IDLE) begin
                    state_nx = ST_IDLE;
                end else if (status_hit && cmd == CMD_RUN) begin
                    wd_nx = '0;
                end else if (status_hit && cmd == CMD_PASS) begin
                    state_nx = ST_PASS;
                end else if (status_hit && cmd == CMD_FAIL) begin
                    state_nx = ST_FAIL;
                end else if (heart_hit) begin
                    wd_nx = '0;
                end else if (&wd) begin
                    state_nx   = ST_FAIL;
                    timeout_nx = 1'b1;
                end else begin
                    wd_nx = wd + WD_W'(1);
                end
            end
            ST_PASS, ST_FAIL: begin
                if (status_hit && cmd == CMD_IDLE) begin
                    state_nx   = ST_IDLE;
                    timeout_nx = 1'b0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

`ifdef LED_BLINK_EN
    localparam int unsigned BLINK_W = BLINK_BITS;

    logic [BLINK_W-1:0] blink, blink_nx;

    // Free-running blink divider while in RUN, held at zero elsewhere.
    always_comb begin
        blink_nx = '0;
        if (state == ST_RUN && state_nx == ST_RUN) begin
            blink_nx = blink + BLINK_W'(1);
        end
    end

    assign run_led_nx = (state_nx == ST_RUN) & blink_nx[BLINK_W-1];

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            blink <= '0;
        end else begin
            blink <= blink_nx;
        end
    end
`else
    logic [BLINK_BITS-1:0] unused_blink;

    assign unused_blink = '0;
    assign run_led_nx   = (state_nx == ST_RUN);
`endif

    // State register. The LEDs are registered from the next state, so they
    // change on the same edge as the state register.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wd         <= '0;
            timeout    <= 1'b0;
            outputleds <= 4'b0000;
        end else begin
            state      <= state_nx;
            wd         <= wd_nx;
            timeout    <= timeout_nx;
            outputleds <= {run_led_nx,
                           state_nx == ST_PASS,
                           state_nx == ST_FAIL,
                           1'b1};
        end
    end

    assign readdata = {29'b0, timeout, state};

endmodule

// File: tb/tb_led_status_port.sv
// tb_led_status_port: directed and randomized bench for led_status_port.
// It uses a short watchdog (TIMEOUT_BITS=4) and checks the LEDs and the
// readback against a behavioural model on every cycle.
module tb_led_status_port;

    localparam int unsigned TB_TO   = 4;
    localparam int          LIMIT   = 1 << TB_TO;
    localparam logic [31:0] STATUS  = 32'hFFFF_FFF0;
    localparam logic [31:0] HEART   = 32'hFFFF_FFF4;
    localparam logic [31:0] OTHER   = 32'hFFFF_FFF8;

    logic        ph1;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  outputleds;

    int checks = 0;
    int errors = 0;

    // Model state: 0 idle, 1 running, 2 passed, 3 failed.
    int m_state;
    int m_to;
    int m_pow;
    int m_quiet;   // cycles spent in RUN since the last kick

    led_status_port #(
        .STATUS_ADDR (STATUS),
        .HEART_ADDR  (HEART),
        .TIMEOUT_BITS(TB_TO),
        .BLINK_BITS  (22)
    ) dut (
        .ph1       (ph1),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .outputleds(outputleds)
    );

    initial begin
        ph1 = 1'b1;
        forever #5 ph1 = ~ph1;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    function automatic void model_reset();
        m_state = 0;
        m_to    = 0;
        m_pow   = 0;
        m_quiet = 0;
    endfunction

    // One rising edge of the behavioural model.
    function automatic void model_edge(input logic mw, input logic [31:0] adr,
                                       input logic [31:0] data);
        int  cmd;
        bit  st;
        bit  hb;
        cmd   = int'(data[7:0]);
        st    = mw && (adr == STATUS);
        hb    = mw && (adr == HEART);
        m_pow = 1;
        if (m_state == 0) begin
            if (st && cmd == 1) begin
                m_state = 1;
                m_quiet = 0;
                m_to    = 0;
            end
        end else if (m_state == 1) begin
            if (st && cmd <= 3) begin
                m_state = (cmd == 0) ? 0 : (cmd == 1) ? 1 : cmd;
                m_quiet = 0;
            end else if (hb) begin
                m_quiet = 0;
            end else if (m_quiet + 1 >= LIMIT) begin
                m_state = 3;
                m_to    = 1;
            end else begin
                m_quiet = m_quiet + 1;
            end
        end else begin
            if (st && cmd == 0) begin
                m_state = 0;
                m_to    = 0;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [3:0]  el;
        logic [31:0] er;
        el = {m_state == 1, m_state == 2, m_state == 3, m_pow != 0};
        er = 32'(m_to * 4 + m_state);
        checks++;
        assert (outputleds === el) else begin
            errors++;
            $error("FAIL %s leds: observed %b expected %b", tag, outputleds, el);
        end
        checks++;
        assert (readdata === er) else begin
            errors++;
            $error("FAIL %s readdata: observed %h expected %h", tag, readdata, er);
        end
    endtask

    task automatic check_const(input string tag, input logic [3:0] el,
                               input logic [31:0] er);
        checks++;
        assert (outputleds === el) else begin
            errors++;
            $error("FAIL %s leds: observed %b expected %b", tag, outputleds, el);
        end
        checks++;
        assert (readdata === er) else begin
            errors++;
            $error("FAIL %s readdata: observed %h expected %h", tag, readdata, er);
        end
    endtask

    // Drive one cycle at the falling edge and check at the next falling edge.
    task automatic step(input logic mw, input logic [31:0] adr,
                        input logic [31:0] data, input string tag);
        memwrite  = mw;
        dataadr   = adr;
        writedata = data;
        @(posedge ph1);
        model_edge(mw, adr, data);
        @(negedge ph1);
        memwrite = 1'b0;
        check_model(tag);
    endtask

    task automatic store(input logic [31:0] data, input string tag);
        step(1'b1, STATUS, data, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, tag);
    endtask

    task automatic rand_step(input int idle_pct, input int stat_pct, input int hb_pct);
        int          r;
        int          c;
        logic [31:0] d;
        r = int'($urandom_range(0, 99));
        d = $urandom;
        if (r < idle_pct) begin
            step(1'b0, ($urandom_range(0, 1) != 0) ? STATUS : $urandom, d, "rnd_idle");
        end else if (r < idle_pct + stat_pct) begin
            c = int'($urandom_range(0, 5));
            if (c < 4) d[7:0] = 8'(c);
            else if (c == 4) d[7:0] = 8'($urandom_range(4, 255));
            step(1'b1, STATUS, d, "rnd_cmd");
        end else if (r < idle_pct + stat_pct + hb_pct) begin
            step(1'b1, HEART, d, "rnd_heart");
        end else begin
            step(1'b1, ($urandom_range(0, 1) != 0) ? OTHER : $urandom, d, "rnd_other");
        end
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        model_reset();

        // Reset held for 15 ns, with a clock edge inside it.
        @(posedge ph1);
        #2;
        check_const("reset", 4'b0000, 32'h0);
        check_model("reset_model");
        @(negedge ph1);
        reset = 1'b1;
        step(1'b0, 32'h0, 32'h0, "power");
        check_const("power", 4'b0001, 32'h0);

        // Pass flow.
        store(32'h01, "pass_run");
        check_const("pass_run", 4'b1001, 32'h1);
        store(32'h02, "pass");
        check_const("pass", 4'b0101, 32'h2);
        store(32'h00, "pass_clear");
        check_const("pass_clear", 4'b0001, 32'h0);

        // Fail is sticky against a later PASS.
        store(32'h01, "fail_run");
        store(32'h03, "fail");
        store(32'h02, "fail_sticky");
        check_const("fail_sticky", 4'b0011, 32'h3);
        store(32'h00, "fail_clear");
        check_const("fail_clear", 4'b0001, 32'h0);

        // Watchdog expiry after 16 quiet cycles.
        store(32'h01, "wd_run");
        idle(LIMIT - 1, "wd_quiet");
        check_const("wd_before", 4'b1001, 32'h1);
        idle(1, "wd_expire");
        check_const("wd_expired", 4'b0011, 32'h7);
        store(32'h00, "wd_clear");
        check_const("wd_clear", 4'b0001, 32'h0);

        // Regular heartbeats keep RUN alive.
        store(32'h01, "hb_run");
        for (int i = 0; i < 10; i++) begin
            idle(9, "hb_quiet");
            step(1'b1, HEART, $urandom, "hb_kick");
        end
        check_const("hb_alive", 4'b1001, 32'h1);
        store(32'h00, "hb_clear");

        // Ignored stores.
        store(32'h02, "idle_pass");
        check_const("idle_pass", 4'b0001, 32'h0);
        step(1'b1, OTHER, 32'h01, "other_addr");
        check_const("other_addr", 4'b0001, 32'h0);
        step(1'b0, STATUS, 32'h01, "no_strobe");
        check_const("no_strobe", 4'b0001, 32'h0);
        store(32'hABCD_EF01, "upper_bits");
        check_const("upper_bits", 4'b1001, 32'h1);

        // Heartbeat, then a PASS, landing exactly on the expiry cycle.
        idle(LIMIT - 1, "exp_quiet");
        step(1'b1, HEART, 32'h0, "exp_heart");
        check_const("exp_heart", 4'b1001, 32'h1);
        idle(LIMIT - 1, "exp_quiet2");
        store(32'h02, "exp_pass");
        check_const("exp_pass", 4'b0101, 32'h2);
        store(32'h00, "exp_clear");

        // Unknown command in RUN, then RUN back to IDLE.
        store(32'h01, "unk_run");
        store(32'h7F, "unk_cmd");
        check_const("unk_cmd", 4'b1001, 32'h1);
        store(32'h00, "run_idle");
        check_const("run_idle", 4'b0001, 32'h0);

        // Asynchronous reset in RUN.
        store(32'h01, "rst_run");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_const("rst_mid", 4'b0000, 32'h0);
        @(negedge ph1);
        check_const("rst_hold", 4'b0000, 32'h0);
        reset = 1'b1;
        step(1'b0, 32'h0, 32'h0, "rst_power");
        check_const("rst_power", 4'b0001, 32'h0);

        // Random traffic: bus-heavy mix, then a quiet mix that lets the
        // watchdog expire.
        for (int i = 0; i < 300; i++) rand_step(45, 25, 20);
        for (int i = 0; i < 500; i++) rand_step(85, 10, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
